// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port VRAM between display reads (always win) and a queued writer drained in blanking.
// Define VRAM_ARB_ACTIVE_WRITE_EN to also drain writes during active video on idle cycles.
module vram_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 8,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int QDEPTH   = 4
) (
  input  logic                      clock_25_mhz,
  input  logic                      reset,
  input  logic [9:0]                hcount,
  input  logic [9:0]                vcount,
  input  logic                      disp_req,
  input  logic [ADDR_W-1:0]         disp_addr,
  output logic                      disp_valid,
  output logic [DATA_W-1:0]         disp_data,
  input  logic                      wr_valid,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  output logic                      wr_ready,
  output logic [$clog2(QDEPTH):0]   q_level,
  output logic                      ram_en,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_wdata,
  input  logic [DATA_W-1:0]         ram_rdata
);
  localparam int PW = $clog2(QDEPTH);
  localparam logic [9:0] HA = 10'(H_ACTIVE);
  localparam logic [9:0] VA = 10'(V_ACTIVE);
`ifdef VRAM_ARB_ACTIVE_WRITE_EN
  localparam bit ACT_WR = 1'b1;
`else
  localparam bit ACT_WR = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] qa [QDEPTH];
  logic [DATA_W-1:0] qd [QDEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [PW:0] cnt_q, cnt_d;
  logic rdy_q, vld_q, blank, push, pop;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  assign blank = (hcount >= HA) || (vcount >= VA);
  assign push = wr_valid && rdy_q;
  assign pop = state_d == WR;
  always_comb begin
    state_d = disp_req ? RD : ((blank || ACT_WR) && cnt_q != '0) ? WR : IDLE;
    addr_d = state_d == RD ? disp_addr : state_d == WR ? qa[rp_q] : addr_q;
    wd_d = state_d == WR ? qd[rp_q] : wd_q;
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  end
  always_ff @(posedge clock_25_mhz or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      rdy_q <= 1'b0;
      vld_q <= 1'b0;
      addr_q <= '0;
      wd_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wp_q <= wp_q + PW'(push);
      rp_q <= rp_q + PW'(pop);
      rdy_q <= cnt_d != (PW+1)'(QDEPTH);
      vld_q <= state_q == RD;
      addr_q <= addr_d;
      wd_q <= wd_d;
    end
  end
  // Queue storage needs no reset; pointers and count define what is valid.
  always_ff @(posedge clock_25_mhz) begin
    if (push) begin
      qa[wp_q] <= wr_addr;
      qd[wp_q] <= wr_data;
    end
  end
  assign ram_en = state_q != IDLE;
  assign ram_we = state_q == WR;
  assign ram_addr = addr_q;
  assign ram_wdata = wd_q;
  assign disp_valid = vld_q;
  assign disp_data = ram_rdata;
  assign wr_ready = rdy_q;
  assign q_level = cnt_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed checks of read latency, queued writes, blank-gated drain and async reset.
module tb_vram_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [9:0] hcount = 10'd100, vcount = 10'd100;
  logic disp_req = 1'b0, wr_valid = 1'b0;
  logic [11:0] disp_addr = '0, wr_addr = '0, ram_addr;
  logic [7:0] wr_data = '0, disp_data, ram_wdata, ram_rdata = '0;
  logic disp_valid, wr_ready, ram_en, ram_we;
  logic [2:0] q_level;
  int n_cmp = 0, n_bad = 0;
`ifdef VRAM_ARB_ACTIVE_WRITE_EN
  localparam bit AW = 1'b1;
`else
  localparam bit AW = 1'b0;
`endif
  vram_arbiter dut (
    .clock_25_mhz(clk), .reset(rst), .hcount(hcount), .vcount(vcount),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_valid(disp_valid), .disp_data(disp_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready), .q_level(q_level),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (ram_en && !ram_we) ram_rdata <= 8'(ram_addr + 12'd1);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  logic [11:0] exp_addr [6] = '{12'h300, 12'h200, 12'h302, 12'h201, 12'h304, 12'h304};
  logic exp_en [6] = '{1, 1, 1, 1, 1, 0};
  logic exp_we [6] = '{0, 1, 0, 1, 0, 0};
  initial begin
    @(negedge clk);
    tick;
    check("rst_en", ram_en, 0);
    check("rst_lvl", q_level, 0);
    check("rst_rdy", wr_ready, 0);
    check("rst_vld", disp_valid, 0);
    check("rst_addr", ram_addr, 0);
    rst = 1'b0;
    tick;
    check("rdy_after_rst", wr_ready, 1);
    check("idle_en", ram_en, 0);
    for (int i = 0; i < 20; i++) begin
      disp_req = i < 16;
      disp_addr = 12'(i);
      tick;
      check("rd_vld", disp_valid, i >= 1 && i < 17);
      if (i >= 1 && i < 17) check("rd_data", disp_data, i);
      check("rd_no_we", ram_we, 0);
    end
    disp_req = 1'b0;
    hcount = 10'd10;
    vcount = 10'd10;
    for (int k = 0; k < 5; k++) begin
      wr_valid = 1'b1;
      wr_addr = 12'h100 + 12'(k);
      wr_data = 8'hA0 + 8'(k);
      tick;
      check("fill_lvl", q_level, k < 4 ? k + 1 : 4);
      check("fill_rdy", wr_ready, k < 3);
      check("fill_no_we", ram_we, 0);
    end
    wr_valid = 1'b0;
    hcount = 10'd639;
    tick;
    check("h639_no_we", ram_we, 0);
    check("h639_lvl", q_level, 4);
    hcount = 10'd640;
    for (int k = 0; k < 4; k++) begin
      tick;
      check("drain_we", ram_we, 1);
      check("drain_addr", ram_addr, 12'h100 + 12'(k));
      check("drain_data", ram_wdata, 8'hA0 + 8'(k));
      check("drain_lvl", q_level, 3 - k);
      check("drain_rdy", wr_ready, 1);
    end
    tick;
    check("drained_en", ram_en, 0);
    hcount = 10'd10;
    for (int k = 0; k < 2; k++) begin
      wr_valid = 1'b1;
      wr_addr = 12'h200 + 12'(k);
      wr_data = 8'hB0 + 8'(k);
      tick;
    end
    wr_valid = 1'b0;
    check("il_lvl", q_level, 2);
    hcount = 10'd700;
    for (int i = 0; i < 6; i++) begin
      disp_req = (i % 2) == 0;
      disp_addr = 12'h300 + 12'(i);
      tick;
      check("il_en", ram_en, exp_en[i]);
      check("il_we", ram_we, exp_we[i]);
      check("il_addr", ram_addr, exp_addr[i]);
      if (exp_we[i]) check("il_data", ram_wdata, 8'hB0 + 8'(i / 2));
    end
    disp_req = 1'b0;
    hcount = 10'd10;
    wr_valid = 1'b1;
    wr_addr = 12'h3FF;
    wr_data = 8'h55;
    tick;
    wr_valid = 1'b0;
    check("pre_rst_lvl", q_level, 1);
    disp_req = 1'b1;
    disp_addr = 12'h020;
    tick;
    check("pre_rst_rd", ram_en, 1);
    disp_req = 1'b0;
    rst = 1'b1;
    #1;
    check("arst_en", ram_en, 0);
    check("arst_lvl", q_level, 0);
    check("arst_rdy", wr_ready, 0);
    for (int i = 0; i < 2; i++) begin
      tick;
      check("arst_vld", disp_valid, 0);
    end
    rst = 1'b0;
    tick;
    check("post_rst_vld", disp_valid, 0);
    check("post_rst_lvl", q_level, 0);
    check("post_rst_rdy", wr_ready, 1);
    hcount = 10'd200;
    vcount = 10'd10;
    wr_valid = 1'b1;
    wr_addr = 12'h0AB;
    wr_data = 8'h77;
    tick;
    wr_valid = 1'b0;
    check("act_we0", ram_we, 0);
    tick;
    check("act_we1", ram_we, AW);
    tick;
    check("act_we2", ram_we, 0);
    hcount = 10'd640;
    tick;
    check("blank_we", ram_we, !AW);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
